alarm_bank: RTL and testbench

//  Multi-channel alarm unit; parametrised successor of the single-alarm block.

---
 rtl/alarm_bank.sv | 173 +++++++++++++++++
 tb/tb_alarm_bank.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank.sv
// Multi-channel HH:MM alarm unit with per-channel enable, shared hour/minute editing,
// bounded ring duration, global snooze (limited per trigger) and stop.
module alarm_bank #(
    parameter int N_ALARMS     = 4,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_SECONDS = 60,
    parameter int MAX_SNOOZES  = 3,
    localparam int SW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    input  logic [1:0]          edit_btns,
    input  logic                enable_tgl,
    input  logic                snooze,
    input  logic                stop,
    input  logic                sec_tick,
    input  logic [16:0]         current_time,
    output logic [16:0]         alarm_time,
    output logic [N_ALARMS-1:0] alarm_en,
    output logic [N_ALARMS-1:0] ringing,
    output logic                alarm
);
    localparam int CW = $clog2(MAX_SNOOZES + 2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    logic [4:0]              cur_hh;
    logic [5:0]              cur_mm;
    logic [5:0]              cur_ss;
    logic                    sel_valid;
    logic                    edit_ok;
    logic [6:0]              mm_sum;
    logic [4:0]              snz_hh;
    logic [5:0]              snz_mm;
    logic [N_ALARMS*5-1:0]   hh_all;
    logic [N_ALARMS*6-1:0]   mm_all;

    assign cur_hh = current_time[16:12];
    assign cur_mm = current_time[11:6];
    assign cur_ss = current_time[5:0];

    // Snooze target is shared: every ringing channel snoozes to the same wall time.
    always_comb begin
        sel_valid = int'(sel) < N_ALARMS;
        edit_ok   = mode && sel_valid;
        mm_sum    = {1'b0, cur_mm} + 7'(SNOOZE_MIN);
        snz_hh    = cur_hh;
        snz_mm    = mm_sum[5:0];
        if (mm_sum >= 7'd60) begin
            snz_mm = 6'(mm_sum - 7'd60);
            snz_hh = (cur_hh == 5'd23) ? 5'd0 : cur_hh + 5'd1;
        end
    end

    always_comb begin
        alarm_time = '0;
        if (sel_valid) begin
            alarm_time = {hh_all[int'(sel)*5 +: 5], mm_all[int'(sel)*6 +: 6], 6'd0};
        end
    end

    generate
        for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
            state_t          state_reg, state_next;
            logic [4:0]      hh_reg, hh_next;
            logic [5:0]      mm_reg, mm_next;
            logic            en_reg, en_next;
            logic            match_hist_reg;
            logic [7:0]      ring_cnt_reg, ring_cnt_next;
            logic [CW-1:0]   snz_cnt_reg, snz_cnt_next;
            logic [4:0]      tgt_hh_reg, tgt_hh_next;
            logic [5:0]      tgt_mm_reg, tgt_mm_next;
            logic            sel_hit, touched, match, trigger, tgt_hit;

            always_comb begin
                sel_hit  = edit_ok && (sel == SW'(gi));
                touched  = sel_hit && ((edit_btns != 2'b00) || enable_tgl);
                match    = en_reg && (cur_hh == hh_reg) && (cur_mm == mm_reg) && (cur_ss == 6'd0);
                trigger  = match && !match_hist_reg;
                tgt_hit  = (cur_hh == tgt_hh_reg) && (cur_mm == tgt_mm_reg) && (cur_ss == 6'd0);

                hh_next       = hh_reg;
                mm_next       = mm_reg;
                en_next       = en_reg;
                state_next    = state_reg;
                ring_cnt_next = ring_cnt_reg;
                snz_cnt_next  = snz_cnt_reg;
                tgt_hh_next   = tgt_hh_reg;
                tgt_mm_next   = tgt_mm_reg;

                if (sel_hit) begin
                    if (edit_btns[1]) hh_next = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
                    if (edit_btns[0]) mm_next = (mm_reg == 6'd59) ? 6'd0 : mm_reg + 6'd1;
                    if (enable_tgl)   en_next = !en_reg;
                end

                if (stop || touched || !en_reg) begin
                    state_next = IDLE;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (trigger) begin
                                state_next    = RINGING;
                                ring_cnt_next = '0;
                                snz_cnt_next  = '0;
                            end
                        end
                        RINGING: begin
                            if (snooze) begin
                                if (int'(snz_cnt_reg) < MAX_SNOOZES) begin
                                    state_next   = SNOOZED;
                                    tgt_hh_next  = snz_hh;
                                    tgt_mm_next  = snz_mm;
                                    snz_cnt_next = snz_cnt_reg + CW'(1);
                                end else begin
                                    state_next = IDLE;
                                end
                            end else if (sec_tick) begin
                                if (ring_cnt_reg == 8'(RING_SECONDS - 1)) state_next = IDLE;
                                else ring_cnt_next = ring_cnt_reg + 8'd1;
                            end
                        end
                        SNOOZED: begin
                            if (tgt_hit) begin
                                state_next    = RINGING;
                                ring_cnt_next = '0;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg      <= IDLE;
                    hh_reg         <= '0;
                    mm_reg         <= '0;
                    en_reg         <= 1'b0;
                    match_hist_reg <= 1'b0;
                    ring_cnt_reg   <= '0;
                    snz_cnt_reg    <= '0;
                    tgt_hh_reg     <= '0;
                    tgt_mm_reg     <= '0;
                end else begin
                    state_reg      <= state_next;
                    hh_reg         <= hh_next;
                    mm_reg         <= mm_next;
                    en_reg         <= en_next;
                    match_hist_reg <= match;
                    ring_cnt_reg   <= ring_cnt_next;
                    snz_cnt_reg    <= snz_cnt_next;
                    tgt_hh_reg     <= tgt_hh_next;
                    tgt_mm_reg     <= tgt_mm_next;
                end
            end

            assign hh_all[gi*5 +: 5] = hh_reg;
            assign mm_all[gi*6 +: 6] = mm_reg;
            assign alarm_en[gi]      = en_reg;
            assign ringing[gi]       = (state_reg == RINGING);
        end
    endgenerate

    assign alarm = |ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed and randomized checks of alarm_bank against a minutes-of-day reference model.
module tb_alarm_bank;
    localparam int N     = 4;
    localparam int SNZ   = 5;
    localparam int RING  = 60;
    localparam int MAXS  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic [1:0]  edit_btns;
    logic        enable_tgl, snooze, stop, sec_tick;
    logic [16:0] current_time;
    logic [16:0] alarm_time;
    logic [3:0]  alarm_en, ringing;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    // Reference model: settings as minutes of day, ringing as remaining seconds.
    int set_min [N];
    bit m_en    [N];
    bit m_ring  [N];
    bit m_snz   [N];
    int m_left  [N];
    int m_used  [N];
    int m_tgt   [N];
    bit m_prev  [N];

    alarm_bank dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel), .edit_btns(edit_btns),
        .enable_tgl(enable_tgl), .snooze(snooze), .stop(stop), .sec_tick(sec_tick),
        .current_time(current_time), .alarm_time(alarm_time), .alarm_en(alarm_en),
        .ringing(ringing), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            set_min[i] = 0; m_en[i] = 0; m_ring[i] = 0; m_snz[i] = 0;
            m_left[i] = 0; m_used[i] = 0; m_tgt[i] = 0; m_prev[i] = 0;
        end
    endtask

    task automatic model_update();
        int now, ss, h, m;
        bit match, hit, touched, en_old;
        now = int'(current_time[16:12]) * 60 + int'(current_time[11:6]);
        ss  = int'(current_time[5:0]);
        for (int i = 0; i < N; i++) begin
            match   = m_en[i] && (set_min[i] == now) && (ss == 0);
            hit     = mode && (int'(sel) == i);
            touched = hit && ((edit_btns != 2'b00) || enable_tgl);
            en_old  = m_en[i];
            if (hit) begin
                h = set_min[i] / 60;
                m = set_min[i] % 60;
                if (edit_btns[1]) h = (h + 1) % 24;
                if (edit_btns[0]) m = (m + 1) % 60;
                set_min[i] = h * 60 + m;
                if (enable_tgl) m_en[i] = !m_en[i];
            end
            if (stop || touched || !en_old) begin
                m_ring[i] = 0; m_snz[i] = 0;
            end else if (m_ring[i]) begin
                if (snooze) begin
                    m_ring[i] = 0;
                    if (m_used[i] < MAXS) begin
                        m_snz[i] = 1;
                        m_tgt[i] = (now + SNZ) % 1440;
                        m_used[i]++;
                    end
                end else if (sec_tick) begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_ring[i] = 0;
                end
            end else if (m_snz[i]) begin
                if (now == m_tgt[i] && ss == 0) begin
                    m_snz[i] = 0; m_ring[i] = 1; m_left[i] = RING;
                end
            end else if (match && !m_prev[i]) begin
                m_ring[i] = 1; m_left[i] = RING; m_used[i] = 0;
            end
            m_prev[i] = match;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [3:0]  er, ee;
        logic [16:0] et;
        for (int i = 0; i < N; i++) begin
            er[i] = m_ring[i];
            ee[i] = m_en[i];
        end
        et = 17'(((set_min[sel] / 60) << 12) | ((set_min[sel] % 60) << 6));
        chk({tag, "/ringing"}, 32'(ringing), 32'(er));
        chk({tag, "/alarm"}, 32'(alarm), 32'(er != 4'd0));
        chk({tag, "/alarm_en"}, 32'(alarm_en), 32'(ee));
        chk({tag, "/alarm_time"}, 32'(alarm_time), 32'(et));
    endtask

    task automatic clear_pulses();
        edit_btns = 2'b00; enable_tgl = 0; snooze = 0; stop = 0; sec_tick = 0;
    endtask

    task automatic step(input string tag);
        if (edit_btns != 2'b00 || enable_tgl || snooze || stop)
            $display("%s: t=%0t mode=%0b sel=%0d btn=%b tgl=%b snz=%b stop=%b time=%h", tag, $time,
                     mode, sel, edit_btns, enable_tgl, snooze, stop, current_time);
        model_update();
        @(posedge clk);
        #1;
        compare_all(tag);
        clear_pulses();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        current_time = {5'(h), 6'(m), 6'(s)};
    endtask

    task automatic press(input logic [1:0] btn, input int n, input string tag);
        repeat (n) begin
            edit_btns = btn;
            step(tag);
        end
    endtask

    task automatic do_reset(input bit check_all_sel);
        reset = 1; mode = 0; sel = 0;
        clear_pulses();
        set_time(12, 34, 56);
        @(posedge clk);
        #1;
        model_reset();
        if (check_all_sel) begin
            for (int i = 0; i < N; i++) begin
                sel = 2'(i);
                #1;
                chk("reset/alarm_time", 32'(alarm_time), 32'd0);
                chk("reset/alarm_en", 32'(alarm_en), 32'd0);
                chk("reset/alarm", 32'(alarm), 32'd0);
            end
            sel = 0;
        end
        reset = 0;
        $display("reset: t=%0t", $time);
    endtask

    initial begin
        int r, k, t;
        // 1: reset state on every channel
        do_reset(1);

        // 2: channel 1 at 07:30 rings for RING seconds
        mode = 1; sel = 1;
        press(2'b10, 7, "t2_hour");
        press(2'b01, 30, "t2_min");
        enable_tgl = 1; step("t2_tgl");
        mode = 0;
        set_time(7, 30, 0); step("t2_match");
        chk("t2_ring_rise", 32'(ringing), 32'h2);
        repeat (RING - 1) begin sec_tick = 1; step("t2_tick"); end
        chk("t2_ring_hold", 32'(ringing), 32'h2);
        sec_tick = 1; step("t2_tick");
        chk("t2_ring_off", 32'(ringing), 32'h0);

        // 3: minute and hour wrap
        do_reset(0);
        mode = 1; sel = 0;
        press(2'b01, 59, "t3_min");
        chk("t3_min59", 32'(alarm_time), 32'(59 << 6));
        press(2'b01, 1, "t3_min_wrap");
        chk("t3_min_wrap", 32'(alarm_time), 32'h0);
        press(2'b10, 23, "t3_hour");
        chk("t3_hour23", 32'(alarm_time), 32'(23 << 12));
        press(2'b10, 1, "t3_hour_wrap");
        chk("t3_hour_wrap", 32'(alarm_time), 32'h0);
        press(2'b11, 1, "t3_both");
        chk("t3_both", 32'(alarm_time), 32'((1 << 12) | (1 << 6)));

        // 4: snooze across midnight, then snooze budget exhausted
        do_reset(0);
        mode = 1; sel = 3;
        press(2'b10, 23, "t4_hour");
        press(2'b01, 58, "t4_min");
        enable_tgl = 1; step("t4_tgl");
        mode = 0;
        set_time(23, 58, 0); step("t4_match");
        chk("t4_ring", 32'(ringing), 32'h8);
        snooze = 1; step("t4_snooze1");
        chk("t4_snoozed", 32'(ringing), 32'h0);
        set_time(0, 2, 0); step("t4_early");
        chk("t4_early", 32'(ringing), 32'h0);
        set_time(0, 3, 0); step("t4_wake1");
        chk("t4_wake1", 32'(ringing), 32'h8);
        snooze = 1; step("t4_snooze2");
        set_time(0, 8, 0); step("t4_wake2");
        chk("t4_wake2", 32'(ringing), 32'h8);
        snooze = 1; step("t4_snooze3");
        set_time(0, 13, 0); step("t4_wake3");
        chk("t4_wake3", 32'(ringing), 32'h8);
        snooze = 1; step("t4_snooze4");
        chk("t4_exhausted", 32'(ringing), 32'h0);
        set_time(0, 18, 0); step("t4_no_wake");
        chk("t4_no_wake", 32'(ringing), 32'h0);

        // 5: two channels, stop beats snooze, no retrigger while time held
        do_reset(0);
        mode = 1; sel = 0;
        press(2'b10, 6, "t5_h0");
        enable_tgl = 1; step("t5_tgl0");
        sel = 2;
        press(2'b10, 6, "t5_h2");
        enable_tgl = 1; step("t5_tgl2");
        mode = 0;
        set_time(6, 0, 0); step("t5_match");
        chk("t5_ring", 32'(ringing), 32'h5);
        stop = 1; snooze = 1; step("t5_stop");
        chk("t5_stopped", 32'(ringing), 32'h0);
        repeat (5) step("t5_hold");
        chk("t5_no_retrig", 32'(ringing), 32'h0);

        // 6: asynchronous reset while ringing
        do_reset(0);
        mode = 1; sel = 0;
        press(2'b10, 1, "t6_hour");
        enable_tgl = 1; step("t6_tgl");
        mode = 0;
        set_time(1, 0, 0); step("t6_match");
        chk("t6_ring", 32'(alarm), 32'h1);
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        chk("t6_async_alarm", 32'(alarm), 32'h0);
        chk("t6_async_ringing", 32'(ringing), 32'h0);
        chk("t6_async_time", 32'(alarm_time), 32'h0);
        @(posedge clk);
        #1;
        reset = 0;

        // Randomized phase
        do_reset(0);
        for (int c = 0; c < 1500; c++) begin
            mode = ($urandom_range(0, 3) == 0);
            sel  = 2'($urandom_range(0, 3));
            if (mode) begin
                edit_btns  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                enable_tgl = ($urandom_range(0, 4) == 0);
            end
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom_range(0, 9);
                k = $urandom_range(0, N - 1);
                if (r < 5)      t = set_min[k];
                else if (r < 7) t = m_tgt[k];
                else            t = $urandom_range(0, 1439);
                set_time(t / 60, t % 60, ($urandom_range(0, 2) != 0) ? 0 : $urandom_range(1, 59));
            end
            sec_tick = ($urandom_range(0, 1) == 1);
            snooze   = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
